s_p: RTL

Serial-to-parallel input stage of the 16-point radix-4 FFT. It accepts one complex sample per handshake and stores each 16-sample frame in one bank of a ping-pong buffer. It then presents the frame to the butterfly stage as four 4-sample groups on `calc_in`, together with the group's `rotation` index. While one bank drains, the other bank fills, so a continuous input stream is never stalled when the downstream stage accepts every cycle.

---
 rtl/s_p.sv | 104 ++++++++++
 1 files changed

// File: rtl/s_p.sv
// Serial-to-parallel input stage for the 16-point radix-4 FFT.
// Ping-pong buffer: one bank fills sample by sample while the other drains as four stride-4 groups.
module s_p #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_re,
    input  logic [DATA_W-1:0]    in_im,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*OUT_W-1:0]   calc_in,
    output logic [2:0]           rotation,
    output logic                 frame_done
);
    localparam int ENT_W = 2 * OUT_W;

    typedef logic [ENT_W-1:0] entry_t;

    entry_t       mem_q [2][16];
    logic         wr_bank_q, wr_bank_d;
    logic [3:0]   wr_ptr_q, wr_ptr_d;
    logic         rd_bank_q, rd_bank_d;
    logic [1:0]   grp_q, grp_d;
    logic [1:0]   full_q, full_d;
    logic         frame_done_q, frame_done_d;
    logic         in_fire, out_fire;
    entry_t       wr_entry;

    assign in_ready   = !full_q[wr_bank_q];
    assign out_valid  = full_q[rd_bank_q];
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign rotation   = {1'b0, grp_q};
    assign frame_done = frame_done_q;

    // Each stored entry is {Re, Im}, both sign-extended to OUT_W.
    assign wr_entry = {{(OUT_W-DATA_W){in_re[DATA_W-1]}}, in_re,
                       {(OUT_W-DATA_W){in_im[DATA_W-1]}}, in_im};

    // Lane k of the group is sample grp + 4k: the lane number forms the upper index bits.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        assign calc_in[gi*ENT_W +: ENT_W] = mem_q[rd_bank_q][{LANE, grp_q}];
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        grp_d        = grp_q;
        full_d       = full_q;
        frame_done_d = 1'b0;
        if (in_fire) begin
            wr_ptr_d = wr_ptr_q + 4'd1;
            if (wr_ptr_q == 4'd15) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end
        // Writer and reader never touch the same full bit in one cycle, so both updates compose.
        if (out_fire) begin
            grp_d = grp_q + 2'd1;
            if (grp_q == 2'd3) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
                frame_done_d      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            grp_q        <= '0;
            full_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            grp_q        <= grp_d;
            full_q       <= full_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int e = 0; e < 16; e++) begin
                    mem_q[b][e] <= '0;
                end
            end
        end else if (in_fire) begin
            mem_q[wr_bank_q][wr_ptr_q] <= wr_entry;
        end
    end
endmodule
